// File: rtl/fc_irq_ctrl_pkg.sv
// ============================================================================
// Module   : fc_irq_ctrl_pkg
// Brief    : Register map, special IRQ line indices and shared types for the
//            fabric-controller event/interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fc_irq_ctrl_pkg;

    localparam logic [7:0] OFF_MASK      = 8'h00;
    localparam logic [7:0] OFF_MASK_SET  = 8'h04;
    localparam logic [7:0] OFF_MASK_CLR  = 8'h08;
    localparam logic [7:0] OFF_PEND      = 8'h0C;
    localparam logic [7:0] OFF_INT_SET   = 8'h10;
    localparam logic [7:0] OFF_INT_CLR   = 8'h14;
    localparam logic [7:0] OFF_ACK_REG   = 8'h18;
    localparam logic [7:0] OFF_FIFO_DATA = 8'h1C;
    localparam logic [7:0] OFF_FIFO_STAT = 8'h20;

    localparam int IRQ_SOC_EVT   = 26;
    localparam int IRQ_LEVEL_SRC = 11;

    typedef struct packed {
        logic       valid;
        logic [4:0] id;
    } ack_reg_t;

endpackage

`default_nettype wire

// File: rtl/fc_evt_fifo.sv
// ============================================================================
// Module   : fc_evt_fifo
// Brief    : Synchronous FIFO for SoC event IDs with occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fc_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push alongside a pop is taken even when full: the pop frees the slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/fc_event_irq_ctrl.sv
// ============================================================================
// Module   : fc_event_irq_ctrl
// Brief    : Edge-detected pending/mask interrupt vector plus SoC event FIFO,
//            configured and drained over a zero-wait-state APB slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fc_event_irq_ctrl
    import fc_irq_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int EVT_ID_WIDTH   = 8,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [31:0]               irq_src_i,
    input  logic                      soc_evt_valid_i,
    input  logic [EVT_ID_WIDTH-1:0]   soc_evt_id_i,
    output logic                      soc_evt_ready_o,
    input  logic                      irq_ack_i,
    input  logic [4:0]                irq_ack_id_i,
    output logic [31:0]               irq_o,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    input  logic                      apb_pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [31:0]               apb_pwdata_i,
    output logic [31:0]               apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]             src_q, mask_q, mask_d, pend_q, pend_d, irq_q;
    ack_reg_t                ack_q, ack_d;
    logic [7:0]              w_off;
    logic                    w_acc, w_wr, w_rd, w_mapped;
    logic [31:0]             w_rise;
    logic                    fifo_pop, fifo_full, fifo_empty;
    logic [EVT_ID_WIDTH-1:0] fifo_data;
    logic [CW-1:0]           fifo_count;
    logic                    w_unused;

    assign w_off    = apb_paddr_i[7:0];
    assign w_unused = ^apb_paddr_i[APB_ADDR_WIDTH-1:8];
    assign w_acc    = apb_psel_i & apb_penable_i;
    assign w_wr     = w_acc & apb_pwrite_i;
    assign w_rd     = w_acc & ~apb_pwrite_i;
    assign w_rise   = irq_src_i & ~src_q;
    assign fifo_pop = w_rd & (w_off == OFF_FIFO_DATA);

    fc_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_ID_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (soc_evt_valid_i),
        .data_i  (soc_evt_id_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign soc_evt_ready_o = ~fifo_full;
    assign apb_pready_o    = 1'b1;
    assign apb_pslverr_o   = w_acc & ~w_mapped;
    assign irq_o           = irq_q;

    always_comb begin
        w_mapped     = 1'b1;
        apb_prdata_o = '0;
        case (w_off)
            OFF_MASK:      if (w_rd) apb_prdata_o = mask_q;
            OFF_PEND:      if (w_rd) apb_prdata_o = pend_q;
            OFF_ACK_REG:   if (w_rd) apb_prdata_o = 32'(ack_q);
            OFF_FIFO_DATA: if (w_rd && !fifo_empty) apb_prdata_o = 32'(fifo_data);
            OFF_FIFO_STAT: if (w_rd) apb_prdata_o = 32'({fifo_count, fifo_full, fifo_empty});
            OFF_MASK_SET, OFF_MASK_CLR, OFF_INT_SET, OFF_INT_CLR: apb_prdata_o = '0;
            default:       w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        if (w_wr) begin
            case (w_off)
                OFF_MASK:     mask_d = apb_pwdata_i;
                OFF_MASK_SET: mask_d = mask_q | apb_pwdata_i;
                OFF_MASK_CLR: mask_d = mask_q & ~apb_pwdata_i;
                default:      mask_d = mask_q;
            endcase
        end
    end

    // Applied lowest priority first so later assignments win: clear/ack, set, rise.
    always_comb begin
        pend_d = pend_q;
        if (irq_ack_i) pend_d[irq_ack_id_i] = 1'b0;
        if (w_wr) begin
            case (w_off)
                OFF_PEND:    pend_d = apb_pwdata_i;
                OFF_INT_SET: pend_d = pend_d | apb_pwdata_i;
                OFF_INT_CLR: pend_d = pend_d & ~apb_pwdata_i;
                default:     pend_d = pend_d;
            endcase
        end
        pend_d                = pend_d | w_rise;
        pend_d[IRQ_LEVEL_SRC] = irq_src_i[IRQ_LEVEL_SRC];
        pend_d[IRQ_SOC_EVT]   = ~fifo_empty;
    end

    always_comb begin
        ack_d = ack_q;
        if (w_rd && (w_off == OFF_ACK_REG)) ack_d = '0;
        if (irq_ack_i) begin
            ack_d.valid = 1'b1;
            ack_d.id    = irq_ack_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_q  <= '0;
            mask_q <= '0;
            pend_q <= '0;
            irq_q  <= '0;
            ack_q  <= '0;
        end else begin
            src_q  <= irq_src_i;
            mask_q <= mask_d;
            pend_q <= pend_d;
            irq_q  <= pend_d & mask_d;
            ack_q  <= ack_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_event_irq_ctrl.sv
// ============================================================================
// Module   : tb_fc_event_irq_ctrl
// Brief    : Directed self-checking bench for fc_event_irq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fc_event_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] irq_src;
    logic        evt_valid;
    logic [7:0]  evt_id;
    logic        evt_ready;
    logic        ack;
    logic [4:0]  ack_id;
    logic [31:0] irq;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    fc_event_irq_ctrl #(
        .FIFO_DEPTH     (8),
        .EVT_ID_WIDTH   (8),
        .APB_ADDR_WIDTH (12)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .irq_src_i       (irq_src),
        .soc_evt_valid_i (evt_valid),
        .soc_evt_id_i    (evt_id),
        .soc_evt_ready_o (evt_ready),
        .irq_ack_i       (ack),
        .irq_ack_id_i    (ack_id),
        .irq_o           (irq),
        .apb_psel_i      (psel),
        .apb_penable_i   (penable),
        .apb_pwrite_i    (pwrite),
        .apb_paddr_i     (paddr),
        .apb_pwdata_i    (pwdata),
        .apb_prdata_o    (prdata),
        .apb_pready_o    (pready),
        .apb_pslverr_o   (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
        #1 err = pslverr;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        step();
        penable = 1'b1;
        #1;
        d   = prdata;
        err = pslverr;
        step();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_ack(input logic [4:0] id);
        ack = 1'b1; ack_id = id;
        step();
        ack = 1'b0;
    endtask

    task automatic drain8(input string tag);
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < 8; i++) begin
            apb_rd(12'h01C, d, e);
            check(tag, d, 32'(sb_q.pop_front()));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic        acc;

        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        evt_valid = 0; evt_id = '0; ack = 0; ack_id = '0;

        // Reset with all sources high; release with sources low so no rise follows.
        rst_ni = 1'b0; irq_src = '1;
        step(); step();
        rst_ni = 1'b1; irq_src = '0;
        check("rst_irq", irq, 32'h0);
        check("rst_ready", 32'(evt_ready), 32'h1);
        check("rst_pready", 32'(pready), 32'h1);
        apb_rd(12'h020, d, e);
        check("rst_fifo_stat", d, 32'h1);
        apb_rd(12'h00C, d, e);
        check("rst_pend", d, 32'h0);

        // Edge detect and one-cycle latency.
        apb_wr(12'h000, 32'h1, e);
        irq_src[0] = 1'b1;
        check("edge_pre", irq, 32'h0);
        step();
        check("edge_n1", irq, 32'h1);
        do_ack(5'd0);
        check("edge_acked", irq, 32'h0);
        step(); step(); step();
        check("edge_no_reset", irq, 32'h0);

        // Ack colliding with a fresh rise keeps the bit.
        irq_src = '0;
        apb_wr(12'h00C, 32'h0, e);
        apb_wr(12'h000, 32'h8, e);
        apb_wr(12'h010, 32'h8, e);
        check("int_set", irq, 32'h8);
        ack = 1'b1; ack_id = 5'd3; irq_src[3] = 1'b1;
        step();
        ack = 1'b0;
        check("coll_irq", irq, 32'h8);
        apb_rd(12'h00C, d, e);
        check("coll_pend", d, 32'h8);
        apb_rd(12'h018, d, e);
        check("coll_ackreg", d, 32'h23);
        apb_rd(12'h018, d, e);
        check("ackreg_rd_clr", d, 32'h0);
        apb_wr(12'h014, 32'h8, e);
        check("int_clr", irq, 32'h0);

        // Level source follows src[11] with one-cycle delay, ignores ack.
        apb_wr(12'h000, 32'h800, e);
        irq_src[11] = 1'b1;
        check("lvl_pre", irq, 32'h0);
        step();
        check("lvl_hi", irq, 32'h800);
        do_ack(5'd11);
        check("lvl_ack", irq, 32'h800);
        irq_src[11] = 1'b0;
        step();
        check("lvl_lo", irq, 32'h0);

        // APB error handling and read-only write.
        apb_rd(12'h040, d, e);
        check("unmapped_err", 32'(e), 32'h1);
        check("unmapped_data", d, 32'h0);
        apb_wr(12'h018, 32'hFFFF_FFFF, e);
        check("ro_wr_err", 32'(e), 32'h0);
        apb_rd(12'h018, d, e);
        check("ro_wr_ackreg", d, 32'h2B);
        apb_rd(12'h004, d, e);
        check("w1s_read", d, 32'h0);
        check("w1s_read_err", 32'(e), 32'h0);

        // FIFO fill: 9 pushes into 8 entries, the 9th is refused.
        apb_wr(12'h000, 32'h0400_0000, e);
        for (int i = 0; i < 9; i++) begin
            evt_valid = 1'b1; evt_id = 8'(8'h10 + i);
            #1 acc = evt_ready;
            step();
            if (acc) sb_q.push_back(evt_id);
            if (i == 7) check("ready_full", 32'(evt_ready), 32'h0);
        end
        evt_valid = 1'b0;
        apb_rd(12'h020, d, e);
        check("stat_full", d, 32'h22);
        check("irq_soc_evt", irq, 32'h0400_0000);
        drain8("fifo_drain");
        step();
        check("irq_soc_evt_clr", irq, 32'h0);
        apb_rd(12'h01C, d, e);
        check("empty_pop_data", d, 32'h0);
        check("empty_pop_err", 32'(e), 32'h0);

        // Push and pop in the same cycle at full.
        for (int i = 0; i < 8; i++) begin
            evt_valid = 1'b1; evt_id = 8'(8'h30 + i);
            step();
            sb_q.push_back(evt_id);
        end
        evt_valid = 1'b0;
        psel = 1'b1; pwrite = 1'b0; paddr = 12'h01C; penable = 1'b0;
        step();
        penable = 1'b1; evt_valid = 1'b1; evt_id = 8'h38;
        #1 check("simul_pop", prdata, 32'(sb_q.pop_front()));
        step();
        sb_q.push_back(8'h38);
        psel = 1'b0; penable = 1'b0; evt_valid = 1'b0;
        apb_rd(12'h020, d, e);
        check("simul_stat", d, 32'h22);
        drain8("simul_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
